// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding,
// frame layout constants and the default memory depth used across the slice.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_CSUM    = 3'd4,
    ST_RUN     = 3'd5,
    ST_ERROR   = 3'd6
  } state_t;

  localparam int HDR_BYTES         = 2;
  localparam int CSUM_BYTES        = 1;
  localparam int DEFAULT_MEM_WORDS = 1000;

  // True while the loader is still consuming frame bytes.
  function automatic logic is_loading(input state_t s);
    return (s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM});
  endfunction

endpackage

// File: rtl/program_loader_byte_pair_assembler.sv
// Holds the high-byte latch, forms the big-endian {hi,lo} word and keeps the
// running XOR of every frame byte seen so far.
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        xor_en,
  input  logic        hi_en,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic [7:0]  running_xor
);

  logic [7:0] hi_q;

  // The low byte is taken straight from the stream so the word is ready in
  // the same cycle the low byte is accepted.
  assign word = {hi_q, byte_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q        <= 8'h00;
      running_xor <= 8'h00;
    end else begin
      if (clear) begin
        running_xor <= 8'h00;
      end else if (xor_en) begin
        running_xor <= running_xor ^ byte_in;
      end
      if (hi_en) begin
        hi_q <= byte_in;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed, XOR-checked byte stream, writes the
// words into processor memory and releases the processor reset on success.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  output logic [ADDR_W-1:0] load_addr,
  output logic [15:0]       load_data,
  output logic              load_w,
  output logic              cpu_rst,
  output logic              error,
  output logic [ADDR_W-1:0] loaded_words
);

  state_t            state;
  logic [15:0]       len_q;
  logic [15:0]       len_full;
  logic              accept;
  logic              restart;
  logic              xor_en;
  logic              hi_en;
  logic [ADDR_W-1:0] next_count;
  logic [15:0]       word;
  logic [7:0]        running_xor;

  // Gating with rst keeps the stream stalled while the loader is held in reset.
  assign byte_ready = rst && is_loading(state);
  assign accept     = byte_valid && byte_ready;
  assign restart    = reload && (state == ST_RUN || state == ST_ERROR);
  assign xor_en     = accept && (state != ST_CSUM);
  assign hi_en      = accept && (state == ST_DATA_HI);
  assign next_count = loaded_words + ADDR_W'(1);
  assign len_full   = {len_q[15:8], byte_in};

  byte_pair_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (restart),
    .xor_en      (xor_en),
    .hi_en       (hi_en),
    .byte_in     (byte_in),
    .word        (word),
    .running_xor (running_xor)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_LEN_HI;
      len_q        <= 16'h0000;
      load_addr    <= '0;
      load_data    <= 16'h0000;
      load_w       <= 1'b0;
      cpu_rst      <= 1'b0;
      error        <= 1'b0;
      loaded_words <= '0;
    end else begin
      load_w <= 1'b0;
      case (state)
        ST_LEN_HI: begin
          if (accept) begin
            len_q <= {byte_in, 8'h00};
            state <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          // The length is bounded here so no later write can leave memory.
          if (accept) begin
            len_q <= len_full;
            if (len_full > 16'(MEM_WORDS)) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else if (len_full == 16'h0000) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (accept) begin
            state <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (accept) begin
            load_addr    <= ADDR_W'(BASE_ADDR) + loaded_words;
            load_data    <= word;
            load_w       <= 1'b1;
            loaded_words <= next_count;
            if (32'(next_count) == 32'(len_q)) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end
        ST_CSUM: begin
          if (accept) begin
            if (byte_in == running_xor) begin
              state   <= ST_RUN;
              cpu_rst <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
        ST_RUN, ST_ERROR: begin
          if (restart) begin
            state        <= ST_LEN_HI;
            cpu_rst      <= 1'b0;
            error        <= 1'b0;
            loaded_words <= '0;
          end
        end
        default: begin
          state <= ST_ERROR;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good, bad-checksum, oversize, empty,
// gapped/reload and mid-frame reset frames with hand-computed expectations.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        reload;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        load_w;
  logic        cpu_rst;
  logic        error;
  logic [15:0] loaded_words;

  int errors = 0;
  int checks = 0;

  logic [7:0]  frame_q[$];
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];

  program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .reload       (reload),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_w       (load_w),
    .cpu_rst      (cpu_rst),
    .error        (error),
    .loaded_words (loaded_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side view: every strobe seen mid-cycle is one write.
  always @(negedge clk) begin
    if (load_w) begin
      log_addr.push_back(load_addr);
      log_data.push_back(load_data);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    byte_in    = b;
    byte_valid = 1'b1;
    step();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic apply_stimulus(input int max_gap);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 1)));
    end
  endtask

  task automatic check_writes(input string tag, input int n,
                              input logic [15:0] a0, input logic [15:0] d0,
                              input logic [15:0] a1, input logic [15:0] d1);
    check_output({tag, " wcount"}, log_addr.size(), n);
    if (n > 0 && log_addr.size() > 0) begin
      check_output({tag, " waddr0"}, log_addr[0], a0);
      check_output({tag, " wdata0"}, log_data[0], d0);
    end
    if (n > 1 && log_addr.size() > 1) begin
      check_output({tag, " waddr1"}, log_addr[1], a1);
      check_output({tag, " wdata1"}, log_data[1], d1);
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    reload     = 1'b0;

    #3;
    check_output("rst load_addr", load_addr, 16'h0);
    check_output("rst load_data", load_data, 16'h0);
    check_output("rst load_w", load_w, 1'b0);
    check_output("rst cpu_rst", cpu_rst, 1'b0);
    check_output("rst error", error, 1'b0);
    check_output("rst loaded_words", loaded_words, 16'h0);
    check_output("rst byte_ready", byte_ready, 1'b0);
    step();
    rst = 1'b1;
    #1;
    check_output("idle byte_ready", byte_ready, 1'b1);

    // Frame 1 byte by byte, watching write latency and the strobe width.
    log_addr.delete(); log_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    check_output("f1 no early write", load_w, 1'b0);
    send_byte(8'h34, 0);
    check_output("f1 w0 load_w", load_w, 1'b1);
    check_output("f1 w0 addr", load_addr, 16'h0000);
    check_output("f1 w0 data", load_data, 16'h1234);
    check_output("f1 w0 count", loaded_words, 16'd1);
    send_byte(8'hAB, 0);
    check_output("f1 strobe clears", load_w, 1'b0);
    check_output("f1 data holds", load_data, 16'h1234);
    send_byte(8'hCD, 0);
    check_output("f1 w1 load_w", load_w, 1'b1);
    check_output("f1 w1 addr", load_addr, 16'h0001);
    check_output("f1 w1 data", load_data, 16'hABCD);
    check_output("f1 pre-csum cpu_rst", cpu_rst, 1'b0);
    send_byte(8'h42, 0);
    check_output("f1 cpu_rst", cpu_rst, 1'b1);
    check_output("f1 error", error, 1'b0);
    check_output("f1 byte_ready", byte_ready, 1'b0);
    check_output("f1 loaded_words", loaded_words, 16'd2);
    send_byte(8'h55, 0);
    check_output("run ignores bytes", cpu_rst, 1'b1);
    check_writes("f1", 2, 16'h0000, 16'h1234, 16'h0001, 16'hABCD);

    do_reload();
    check_output("reload cpu_rst", cpu_rst, 1'b0);
    check_output("reload loaded_words", loaded_words, 16'd0);
    check_output("reload byte_ready", byte_ready, 1'b1);

    // Bad checksum, with reload held mid-frame to show it is ignored there.
    log_addr.delete(); log_data.delete();
    send_byte(8'h00, 0);
    reload = 1'b1;
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    reload = 1'b0;
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'h43, 0);
    check_output("badcs error", error, 1'b1);
    check_output("badcs cpu_rst", cpu_rst, 1'b0);
    check_output("badcs byte_ready", byte_ready, 1'b0);
    check_writes("badcs", 2, 16'h0000, 16'h1234, 16'h0001, 16'hABCD);
    do_reload();
    check_output("badcs reload error", error, 1'b0);

    // Oversize length 1001.
    log_addr.delete(); log_data.delete();
    send_byte(8'h03, 0);
    send_byte(8'hE9, 0);
    check_output("len1001 error", error, 1'b1);
    check_output("len1001 byte_ready", byte_ready, 1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    check_output("len1001 sticky error", error, 1'b1);
    check_output("len1001 cpu_rst", cpu_rst, 1'b0);
    check_writes("len1001", 0, 16'h0, 16'h0, 16'h0, 16'h0);
    do_reload();

    // Empty frame.
    log_addr.delete(); log_data.delete();
    frame_q = '{8'h00, 8'h00, 8'h00};
    apply_stimulus(0);
    check_output("len0 cpu_rst", cpu_rst, 1'b1);
    check_output("len0 error", error, 1'b0);
    check_output("len0 loaded_words", loaded_words, 16'd0);
    check_writes("len0", 0, 16'h0, 16'h0, 16'h0, 16'h0);
    do_reload();

    // Frame 1 with idle gaps, then reload and a one-word second frame.
    log_addr.delete(); log_data.delete();
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    apply_stimulus(5);
    check_output("gap cpu_rst", cpu_rst, 1'b1);
    check_output("gap error", error, 1'b0);
    check_output("gap loaded_words", loaded_words, 16'd2);
    check_writes("gap", 2, 16'h0000, 16'h1234, 16'h0001, 16'hABCD);
    do_reload();
    check_output("gap reload cpu_rst", cpu_rst, 1'b0);
    log_addr.delete(); log_data.delete();
    frame_q = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
    apply_stimulus(0);
    check_output("f2 cpu_rst", cpu_rst, 1'b1);
    check_output("f2 loaded_words", loaded_words, 16'd1);
    check_writes("f2", 1, 16'h0000, 16'hBEEF, 16'h0, 16'h0);
    do_reload();

    // Asynchronous reset while word 1 waits for its low byte.
    log_addr.delete(); log_data.delete();
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    apply_stimulus(0);
    #2;
    rst = 1'b0;
    #1;
    check_output("midrst load_data", load_data, 16'h0);
    check_output("midrst load_addr", load_addr, 16'h0);
    check_output("midrst loaded_words", loaded_words, 16'h0);
    check_output("midrst load_w", load_w, 1'b0);
    check_output("midrst cpu_rst", cpu_rst, 1'b0);
    check_output("midrst error", error, 1'b0);
    check_output("midrst byte_ready", byte_ready, 1'b0);
    step();
    send_byte(8'hCD, 0);
    check_writes("midrst", 1, 16'h0000, 16'h1234, 16'h0, 16'h0);
    rst = 1'b1;
    log_addr.delete(); log_data.delete();
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    apply_stimulus(0);
    check_output("postrst cpu_rst", cpu_rst, 1'b1);
    check_output("postrst loaded_words", loaded_words, 16'd2);
    check_writes("postrst", 2, 16'h0000, 16'h1234, 16'h0001, 16'hABCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
